rcc_rtc_clk_div_mon: RTL

//  Receive-side checker for the divided HSE_RTC clock. Samples mon_clk (divider output) in the
//  i_clk domain, measures each rising-edge-to-rising-edge period in i_clk cycles and compares it
//  to the programmed ratio. Reports frequency errors, a stopped clock and a lock indication to RCC

---
 rtl/rcc_clk_mon_pkg.sv | 12 +
 rtl/BB_signal_sync.sv | 29 ++
 rtl/rcc_rtc_clk_div_mon.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/rcc_clk_mon_pkg.sv
// Shared definitions for the RCC clock monitors: FSM encodings and the stop-timeout offset.
package rcc_clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        MEASURE   = 2'd2
    } mon_state_e;

    localparam int TIMEOUT_OFFSET = 4;

endpackage

// File: rtl/BB_signal_sync.sv
// Multi-stage flop synchronizer for bringing asynchronous signals into the i_clk domain.
module BB_signal_sync #(
    parameter int STAGE_NUM = 2,
    parameter int DW        = 1
) (
    input  logic          i_clk,
    input  logic          rst_n,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_data
);

    logic [DW-1:0] r_sync [STAGE_NUM];

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGE_NUM; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= i_data;
            for (int i = 1; i < STAGE_NUM; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign o_data = r_sync[STAGE_NUM-1];

endmodule

// File: rtl/rcc_rtc_clk_div_mon.sv
// Receive-side monitor for the divided HSE_RTC clock: measures mon_clk rise-to-rise periods
// in i_clk cycles and flags frequency errors, a stopped clock, and lock.
module rcc_rtc_clk_div_mon
    import rcc_clk_mon_pkg::*;
#(
    parameter int RATIO_WID = 6,
    parameter int TOL       = 0,
    parameter int LOCK_CNT  = 4
) (
    input  logic                 i_clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [RATIO_WID-1:0] ratio,
    input  logic                 mon_clk,
    input  logic                 err_clr,
    output logic [RATIO_WID+1:0] period,
    output logic                 period_vld,
    output logic                 err_freq,
    output logic                 err_stop,
    output logic                 lock
);

    localparam int CW = RATIO_WID + 2;
    localparam int GW = $clog2(LOCK_CNT + 1);

    logic                 w_mon_s;
    logic                 r_mon_d;
    logic                 w_rise;

    mon_state_e           r_state, w_state_nxt;
    logic [RATIO_WID-1:0] r_ratio_q, w_ratio_q_nxt;
    logic [CW-1:0]        r_cnt, w_cnt_nxt;
    logic [GW-1:0]        r_good, w_good_nxt;
    logic [CW-1:0]        r_period, w_period_nxt;
    logic                 r_vld, w_vld_nxt;
    logic                 r_err_freq, w_err_freq_nxt;
    logic                 r_err_stop, w_err_stop_nxt;
    logic                 r_lock, w_lock_nxt;

    logic [CW-1:0]        w_ratio_ext;
    logic [CW-1:0]        w_limit;
    logic [CW-1:0]        w_cnt_inc;
    logic [CW-1:0]        w_diff;
    logic [GW-1:0]        w_good_inc;
    logic                 w_in_tol;
    logic                 w_active;

    BB_signal_sync #(
        .STAGE_NUM (2),
        .DW        (1)
    ) u_mon_sync (
        .i_clk  (i_clk),
        .rst_n  (rst_n),
        .i_data (mon_clk),
        .o_data (w_mon_s)
    );

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mon_d <= 1'b0;
        end else begin
            r_mon_d <= w_mon_s;
        end
    end

    assign w_rise      = w_mon_s & ~r_mon_d;
    assign w_ratio_ext = CW'(r_ratio_q);
    assign w_limit     = {1'b0, r_ratio_q, 1'b0} + CW'(TIMEOUT_OFFSET);
    assign w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);
    assign w_diff      = (r_cnt >= w_ratio_ext) ? (r_cnt - w_ratio_ext) : (w_ratio_ext - r_cnt);
    assign w_in_tol    = (w_diff <= CW'(TOL));
    assign w_good_inc  = (r_good >= GW'(LOCK_CNT)) ? r_good : r_good + GW'(1);
    assign w_active    = en && (ratio >= RATIO_WID'(2));

    always_comb begin
        w_state_nxt    = r_state;
        w_ratio_q_nxt  = r_ratio_q;
        w_cnt_nxt      = r_cnt;
        w_good_nxt     = r_good;
        w_period_nxt   = r_period;
        w_vld_nxt      = 1'b0;
        w_err_freq_nxt = r_err_freq & ~err_clr;
        w_err_stop_nxt = r_err_stop & ~err_clr;
        w_lock_nxt     = r_lock;

        if (!w_active) begin
            w_state_nxt    = IDLE;
            w_cnt_nxt      = '0;
            w_good_nxt     = '0;
            w_period_nxt   = '0;
            w_err_freq_nxt = 1'b0;
            w_err_stop_nxt = 1'b0;
            w_lock_nxt     = 1'b0;
        end else if (r_state == IDLE) begin
            w_state_nxt   = WAIT_EDGE;
            w_ratio_q_nxt = ratio;
            w_cnt_nxt     = CW'(1);
            w_good_nxt    = '0;
        end else if (ratio != r_ratio_q) begin
            // The period in flight belongs to the old ratio, so it is dropped without an error.
            w_state_nxt   = WAIT_EDGE;
            w_ratio_q_nxt = ratio;
            w_cnt_nxt     = CW'(1);
            w_good_nxt    = '0;
            w_lock_nxt    = 1'b0;
        end else begin
            case (r_state)
                WAIT_EDGE: begin
                    if (w_rise) begin
                        w_state_nxt = MEASURE;
                        w_cnt_nxt   = CW'(1);
                    end else if (r_cnt >= w_limit) begin
                        w_err_stop_nxt = 1'b1;
                        w_lock_nxt     = 1'b0;
                        w_good_nxt     = '0;
                        w_cnt_nxt      = CW'(1);
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                MEASURE: begin
                    if (w_rise) begin
                        w_period_nxt = r_cnt;
                        w_vld_nxt    = 1'b1;
                        w_cnt_nxt    = CW'(1);
                        if (w_in_tol) begin
                            w_good_nxt = w_good_inc;
                            if (w_good_inc == GW'(LOCK_CNT)) begin
                                w_lock_nxt = 1'b1;
                            end
                        end else begin
                            w_err_freq_nxt = 1'b1;
                            w_good_nxt     = '0;
                            w_lock_nxt     = 1'b0;
                        end
                    end else if (r_cnt >= w_limit) begin
                        w_state_nxt    = WAIT_EDGE;
                        w_err_stop_nxt = 1'b1;
                        w_lock_nxt     = 1'b0;
                        w_good_nxt     = '0;
                        w_cnt_nxt      = CW'(1);
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ratio_q  <= '0;
            r_cnt      <= '0;
            r_good     <= '0;
            r_period   <= '0;
            r_vld      <= 1'b0;
            r_err_freq <= 1'b0;
            r_err_stop <= 1'b0;
            r_lock     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ratio_q  <= w_ratio_q_nxt;
            r_cnt      <= w_cnt_nxt;
            r_good     <= w_good_nxt;
            r_period   <= w_period_nxt;
            r_vld      <= w_vld_nxt;
            r_err_freq <= w_err_freq_nxt;
            r_err_stop <= w_err_stop_nxt;
            r_lock     <= w_lock_nxt;
        end
    end

    assign period     = r_period;
    assign period_vld = r_vld;
    assign err_freq   = r_err_freq;
    assign err_stop   = r_err_stop;
    assign lock       = r_lock;

endmodule
